// File: rtl/odo_sbox_bank_ld_if.sv
`default_nettype none
// ============================================================================
//  Module      : odo_sbox_bank_ld_if
//  Description : Load-stream and lookup bus bundle for the Odo S-box bank.
//                slave = S-box bank side, master = producer/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface odo_sbox_bank_ld_if #(
    parameter int W     = 6,
    parameter int LANES = 4
);
    logic                 ld_start;
    logic                 ld_valid;
    logic [W-1:0]         ld_data;
    logic                 ld_done;
    logic                 ready;
    logic                 in_valid;
    logic [LANES*W-1:0]   in_data;
    logic                 out_valid;
    logic [LANES*W-1:0]   out_data;
    logic                 perm_err;

    modport slave (
        input  ld_start, ld_valid, ld_data, in_valid, in_data,
        output ld_done, ready, out_valid, out_data, perm_err
    );

    modport master (
        output ld_start, ld_valid, ld_data, in_valid, in_data,
        input  ld_done, ready, out_valid, out_data, perm_err
    );
endinterface
`default_nettype wire

// File: rtl/odo_sbox_bank_ld.sv
`default_nettype none
// ============================================================================
//  Module      : odo_sbox_bank_ld
//  Description : Runtime-loadable S-box table (2**W entries of W bits) with
//                LANES parallel registered lookups. Table is reloaded from a
//                serial word stream; lookups are accepted only while READY.
//                Optional permutation checker: define ODO_SBOX_PERM_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module odo_sbox_bank_ld #(
    parameter int W     = 6,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    odo_sbox_bank_ld_if.slave    sbox
);

    localparam int           c_DEPTH     = 1 << W;
    localparam logic [W-1:0] c_ADDR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [W-1:0]         r_addr;
    logic                 r_ready;
    logic                 r_ld_done;
    logic                 r_out_valid;
    logic [LANES*W-1:0]   r_out_data;
    logic [W-1:0]         r_table [c_DEPTH];
    logic                 w_wr;
    logic                 w_last;
    logic                 w_accept;

    // Lookups are gated by the registered ready flag, so a request arriving
    // alongside ld_start still sees READY and reads the old table.
    assign w_accept = sbox.in_valid && r_ready;

    // Next state and write strobe; ld_start always wins over ld_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sbox.ld_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (sbox.ld_start) begin
                    w_state_nxt = S_LOAD;
                end else if (sbox.ld_valid) begin
                    w_wr = 1'b1;
                    if (r_addr == c_ADDR_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_READY;
                    end
                end
            end
            S_READY: begin
                if (sbox.ld_start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, load address counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_ready   <= 1'b0;
            r_ld_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (w_state_nxt == S_READY);
            r_ld_done <= w_last;
            if (sbox.ld_start) begin
                r_addr <= '0;
            end else if (w_wr) begin
                r_addr <= r_addr + 1'b1;   // wraps to 0 after the last entry
            end
        end
    end

    // Table storage: deliberately unreset so it maps onto LUTRAM/BRAM.
    always_ff @(posedge clk) begin
        if (w_wr) r_table[r_addr] <= sbox.ld_data;
    end

    // Registered multi-lane read; out_data holds when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                for (int l = 0; l < LANES; l++) begin
                    r_out_data[l*W +: W] <= r_table[sbox.in_data[l*W +: W]];
                end
            end
        end
    end

    assign sbox.ready     = r_ready;
    assign sbox.ld_done   = r_ld_done;
    assign sbox.out_valid = r_out_valid;
    assign sbox.out_data  = r_out_data;

`ifdef ODO_SBOX_PERM_CHECK_EN
    logic [c_DEPTH-1:0] r_seen;
    logic               r_dup;
    logic               r_perm_err;
    logic               w_dup_now;

    // A value written twice in one load means the table is not a permutation.
    assign w_dup_now = w_wr && r_seen[sbox.ld_data];

    // Seen-bitmap and sticky duplicate flag; verdict published with ld_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen     <= '0;
            r_dup      <= 1'b0;
            r_perm_err <= 1'b0;
        end else if (sbox.ld_start) begin
            r_seen     <= '0;
            r_dup      <= 1'b0;
            r_perm_err <= 1'b0;
        end else begin
            if (w_wr) begin
                r_seen[sbox.ld_data] <= 1'b1;
                if (w_dup_now) r_dup <= 1'b1;
            end
            if (w_last) r_perm_err <= r_dup | w_dup_now;
        end
    end

    assign sbox.perm_err = r_perm_err;
`else
    assign sbox.perm_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_odo_sbox_bank_ld.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odo_sbox_bank_ld
//  Description : Scoreboard bench for odo_sbox_bank_ld (W=6, LANES=4).
//                Expected lookup results are queued when a request is
//                driven and compared when the output register updates.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_odo_sbox_bank_ld;

`ifdef ODO_SBOX_PERM_CHECK_EN
    localparam bit c_PERM = 1'b1;
`else
    localparam bit c_PERM = 1'b0;
`endif

    typedef struct {
        bit          acc;
        logic [23:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    odo_sbox_bank_ld_if #(.W(6), .LANES(4)) bus ();

    odo_sbox_bank_ld #(.W(6), .LANES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .sbox (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_done  = 0;
    int          n_last  = 0;
    exp_t        q[$];
    logic [23:0] exp_data = '0;
    logic [5:0]  gold  [64];
    logic [5:0]  stage [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pop the scoreboard entry for the request sampled at
    // the preceding edge; out_data must hold whenever nothing was accepted.
    always @(negedge clk) begin
        if (rst) begin
            exp_data = '0;
            q.delete();
        end else begin
            bit exp_v;
            exp_t it;
            exp_v = 1'b0;
            if (q.size() > 0) begin
                it = q.pop_front();
                exp_v = it.acc;
                if (it.acc) exp_data = it.data;
            end
            check("out_valid", bus.out_valid, exp_v);
            check("out_data", bus.out_data, exp_data);
            if (bus.ld_done) n_done++;
        end
    end

    function automatic logic [23:0] exp_of(input logic [5:0] a, b, c, d);
        return {gold[d], gold[c], gold[b], gold[a]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [5:0] a, b, c, d, input bit acc, input bit with_start);
        exp_t it;
        bus.in_valid = 1'b1;
        bus.in_data  = {d, c, b, a};
        if (with_start) bus.ld_start = 1'b1;
        @(posedge clk);
        it.acc  = acc;
        it.data = exp_of(a, b, c, d);
        q.push_back(it);
        #1;
        bus.in_valid = 1'b0;
        bus.ld_start = 1'b0;
    endtask

    task automatic lookup_rand(input int n);
        for (int k = 0; k < n; k++) begin
            lookup(6'($urandom_range(63)), 6'($urandom_range(63)),
                   6'($urandom_range(63)), 6'($urandom_range(63)), 1'b1, 1'b0);
        end
    endtask

    // Stream n entries from stage[first..]; optionally open with ld_start
    // (carrying a junk ld_valid that must be ignored) and with gap cycles.
    task automatic load(input int n, input bit gaps, input bit do_start, input int first);
        if (do_start) begin
            bus.ld_start = 1'b1;
            bus.ld_valid = 1'b1;
            bus.ld_data  = 6'h15;
            step();
            bus.ld_start = 1'b0;
            bus.ld_valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 2)) begin
                bus.ld_valid = 1'b0;
                step();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = stage[first + i];
            step();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic finish_load(input bit exp_perm);
        @(negedge clk);
        check("ready_after_load", bus.ready, 1'b1);
        check("ld_done_pulse", bus.ld_done, 1'b1);
        check("perm_err_at_done", bus.perm_err, exp_perm);
        @(negedge clk);
        check("ld_done_drop", bus.ld_done, 1'b0);
        check("perm_err_hold", bus.perm_err, exp_perm);
        check("ld_done_once", n_done - n_last, 1);
        n_last = n_done;
        for (int i = 0; i < 64; i++) gold[i] = stage[i];
        step();
    endtask

    task automatic junk_valid(input int n);
        for (int k = 0; k < n; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 6'($urandom_range(63));
            step();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic make_t1();
        logic [5:0] t;
        for (int i = 0; i < 64; i++) stage[i] = 6'((i * 5 + 32) % 64);
        t = stage[1];  stage[1]  = stage[3];  stage[3]  = t;
        t = stage[63]; stage[63] = stage[46]; stage[46] = t;
    endtask

    task automatic make_t2();
        for (int i = 0; i < 64; i++) stage[i] = 6'((i * 7 + 3) % 64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        for (int i = 0; i < 64; i++) gold[i] = '0;

        // Reset state, with a lookup request held high throughout.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 1'b0);
        check("rst_ld_done", bus.ld_done, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 24'h0);
        check("rst_perm_err", bus.perm_err, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        lookup(6'd0, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0);
        lookup(6'd4, 6'd5, 6'd6, 6'd7, 1'b0, 1'b0);
        check("idle_ready", bus.ready, 1'b0);

        // First load and the reference lookup.
        make_t1();
        load(64, 1'b0, 1'b1, 0);
        finish_load(1'b0);
        lookup(6'd0, 6'd1, 6'd63, 6'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("lanes_t1", bus.out_data, 24'h806BE0);
        step();
        lookup_rand(8);

        // ld_valid while READY must not touch the table.
        junk_valid(6);
        check("ready_after_junk", bus.ready, 1'b1);
        lookup_rand(6);

        // Load with gaps: not ready after 63 writes, ready after the 64th.
        make_t2();
        load(63, 1'b1, 1'b1, 0);
        check("gap_ready_63", bus.ready, 1'b0);
        load(1, 1'b0, 1'b0, 63);
        finish_load(1'b0);
        lookup_rand(6);

        // Restart after 10 writes; a full 64 are needed again.
        make_t1();
        load(10, 1'b0, 1'b1, 0);
        check("restart_ready_10", bus.ready, 1'b0);
        load(63, 1'b0, 1'b1, 0);
        check("restart_ready_63", bus.ready, 1'b0);
        load(1, 1'b0, 1'b0, 63);
        finish_load(1'b0);
        lookup_rand(6);

        // Lookup in the ld_start cycle reads the old table, then refused.
        lookup(6'd5, 6'd6, 6'd7, 6'd8, 1'b1, 1'b1);
        check("ready_after_start", bus.ready, 1'b0);
        lookup(6'd1, 6'd2, 6'd3, 6'd4, 1'b0, 1'b0);
        make_t2();
        load(64, 1'b0, 1'b0, 0);
        finish_load(1'b0);
        lookup_rand(6);

        // Reset mid-load, stray ld_valid in IDLE, then a full reload.
        make_t1();
        load(30, 1'b0, 1'b1, 0);
        rst = 1'b1;
        step();
        check("midrst_ready", bus.ready, 1'b0);
        check("midrst_out_data", bus.out_data, 24'h0);
        rst = 1'b0;
        junk_valid(8);
        check("idle_junk_ready", bus.ready, 1'b0);
        lookup(6'd9, 6'd9, 6'd9, 6'd9, 1'b0, 1'b0);
        n_last = n_done;
        load(64, 1'b0, 1'b1, 0);
        finish_load(1'b0);
        lookup_rand(6);

        // Duplicate entries: perm_err only when the checker is built in.
        make_t2();
        stage[5] = 6'h11;
        stage[9] = 6'h11;
        load(64, 1'b0, 1'b1, 0);
        finish_load(c_PERM);
        lookup(6'd5, 6'd9, 6'd5, 6'd0, 1'b1, 1'b0);
        check("perm_err_sticky", bus.perm_err, c_PERM);
        make_t2();
        load(64, 1'b0, 1'b1, 0);
        finish_load(1'b0);
        lookup_rand(4);

        repeat (3) step();
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
